// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master on a wired-AND SDA/SCL bus.
//
// A transaction is START, 7 address bits (MSB first), R/W bit, address
// ACK slot, then either one written byte + slave ACK slot or one read byte
// + master ACK slot, then STOP.  An address NACK skips straight to STOP.
// Every bit slot is four quarters (Q0..Q3) of CLK_DIV system clocks each:
// SCL is low in Q0-Q1 and high in Q2-Q3, SDA changes only on the first
// clock of Q0, and incoming bits are sampled on the last clock of Q2.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   start            one-cycle request, taken only while idle
//   rw               0 = write byte, 1 = read byte
//   addr[6:0]        slave address
//   wdata[7:0]       byte to write
//   rdata[7:0]       byte read, valid with done after a read
//   busy             transaction in progress
//   done             one-cycle end-of-transaction pulse
//   ack_err          slave NACKed address or write data
//   SCL              bus clock, always driven
//   SDA              open-drain data (drives 0 or releases)
//   dbg_state[3:0]   current FSM state encoding (0 = IDLE)
//
// Handshake: a request is taken at the clock edge where start=1, the FSM is
// idle, no request is already pending and done is not being pulsed.  The
// transaction starts one edge later; busy stays high until the edge that
// raises done.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA,
    output logic [3:0] dbg_state
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_RW        = 4'd3,
        S_ADDR_ACK  = 4'd4,
        S_WRITE     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_READ      = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_STOP      = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic            pend_q, pend_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ack_err_q, ack_err_d;
    logic            done_q, done_d;

    logic            accept;
    logic            last_clk;
    logic            slot_end;
    logic            sample_pt;
    logic            sda_low;
    logic            sda_in;

    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;

    assign rdata     = rdata_q;
    assign ack_err   = ack_err_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            pend_q    <= 1'b0;
            addr_q    <= 7'd0;
            rw_q      <= 1'b0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        pend_d    = 1'b0;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        accept    = start && (state_q == S_IDLE) && !pend_q && !done_q;
        last_clk  = (qcnt_q == Q_LAST);
        slot_end  = last_clk && (phase_q == 2'd3);
        sample_pt = last_clk && (phase_q == 2'd2);

        // Quarter/phase counters free-run only inside a transaction; they
        // wrap to zero exactly at the end of STOP, so IDLE always sees 0.
        if (state_q != S_IDLE) begin
            if (last_clk) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d  = qcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // The accepted request waits one cycle in pend_q so the
                // START slot begins on the edge after acceptance.
                if (pend_q) begin
                    state_d = S_START;
                end else if (accept) begin
                    pend_d    = 1'b1;
                    addr_d    = addr;
                    rw_d      = rw;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd6;
                end
            end
            S_ADDR: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_RW;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_RW: begin
                if (slot_end) state_d = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                if (sample_pt) ack_err_d = sda_in;
                // ack_err_q already holds this slot's sample by slot_end.
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (ack_err_q)  state_d = S_STOP;
                    else if (rw_q)  state_d = S_READ;
                    else            state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_WDATA_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_WDATA_ACK: begin
                if (sample_pt) ack_err_d = sda_in;
                if (slot_end)  state_d   = S_STOP;
            end
            S_READ: begin
                if (sample_pt) rdata_d = {rdata_q[6:0], sda_in};
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_RDATA_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_RDATA_ACK: begin
                if (slot_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drivers.  Data bits depend only on state/bit_q, which move at
    // slot boundaries, so SDA can only change in Q0.  START and STOP are
    // the two places where SDA deliberately moves while SCL is high.
    always_comb begin
        SCL     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            S_IDLE:      begin SCL = 1'b1;       sda_low = 1'b0;                end
            S_START:     begin SCL = 1'b1;       sda_low = phase_q[1];          end
            S_ADDR:      begin SCL = phase_q[1]; sda_low = !addr_q[bit_q];      end
            S_RW:        begin SCL = phase_q[1]; sda_low = !rw_q;               end
            S_ADDR_ACK:  begin SCL = phase_q[1]; sda_low = 1'b0;                end
            S_WRITE:     begin SCL = phase_q[1]; sda_low = !wdata_q[bit_q];     end
            S_WDATA_ACK: begin SCL = phase_q[1]; sda_low = 1'b0;                end
            S_READ:      begin SCL = phase_q[1]; sda_low = 1'b0;                end
            S_RDATA_ACK: begin SCL = phase_q[1]; sda_low = 1'b1;                end
            S_STOP:      begin SCL = phase_q[1]; sda_low = (phase_q != 2'd3);   end
            default:     begin SCL = 1'b1;       sda_low = 1'b0;                end
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural I2C slave
// at address 7'h57 on a pulled-up SDA line.  A vector table covers writes,
// reads and address NACKs; hand sequences cover reset mid-transfer and a
// back-to-back request around the done pulse.  A bus monitor tracks SDA
// activity while SCL is high and the SCL high/low period lengths.
module tb_i2c_master;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLV_ADDR = 7'h57;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       busy, done, ack_err;
    logic       scl;
    logic [3:0] dbg_state;
    wire        sda_bus;

    // Slave model state.
    logic       slv_low = 1'b0;
    logic [7:0] slv_tx = 8'h00;
    logic       s_act = 1'b0;
    int         s_r = 0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic       s_match = 1'b0;
    logic       s_read = 1'b0;
    logic       s_mack = 1'b1;

    // Bus monitor state.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       cur_scl, cur_sda;
    logic       seen_rise = 1'b0;
    logic       mon_en = 1'b0;
    int         run_len = 0;
    int         falls_hi = 0;
    int         rises_hi = 0;
    int         bus_err = 0;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slv_tx;
        logic       exp_ack_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         exp_rises;
        int         dbl_at;
    } vec_t;

    vec_t vecs[8];

    assign sda_bus = slv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .SCL       (scl),
        .SDA       (sda_bus),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Bus monitor and slave model, evaluated mid-cycle when all is settled.
    always @(negedge clk) begin
        cur_scl = scl;
        cur_sda = sda_bus;

        if (prev_scl && cur_scl && (cur_sda != prev_sda)) begin
            if (!cur_sda) falls_hi = falls_hi + 1;
            else          rises_hi = rises_hi + 1;
        end
        if (cur_scl != prev_scl) begin
            if (mon_en && (!prev_scl || seen_rise) && (run_len != 2 * CLK_DIV))
                bus_err = bus_err + 1;
            if (cur_scl) seen_rise = 1'b1;
            run_len = 1;
        end else begin
            run_len = run_len + 1;
        end
        if (!busy) seen_rise = 1'b0;

        if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
            s_act = 1'b1; s_r = 0; s_sh = 8'h00; slv_low = 1'b0;
            s_match = 1'b0; s_mack = 1'b1;
        end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
            s_act = 1'b0; slv_low = 1'b0;
        end else if (s_act && !prev_scl && cur_scl) begin
            s_r = s_r + 1;
            if (s_r <= 8)                    s_sh = {s_sh[6:0], cur_sda};
            else if (s_r >= 10 && s_r <= 17) s_rx = {s_rx[6:0], cur_sda};
            else if (s_r == 18)              s_mack = cur_sda;
        end else if (s_act && prev_scl && !cur_scl) begin
            slv_low = 1'b0;
            if (s_r == 8) begin
                s_match = (s_sh[7:1] == SLV_ADDR);
                s_read  = s_sh[0];
                slv_low = s_match;
            end else if (s_r >= 9 && s_r <= 16 && s_match && s_read) begin
                slv_low = !slv_tx[16 - s_r];
            end else if (s_r == 17 && s_match && !s_read) begin
                slv_low = 1'b1;
            end
        end

        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Wait (bounded) for done; optionally pulse start at accept+dbl_at.
    task automatic wait_done(input int k, input int dbl_at, output int lat);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            start = (dbl_at != 0 && cyc == k + dbl_at - 1);
            if (done) begin
                lat = cyc - k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", (lat >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Pulse start with the given inputs; return the accepting edge index.
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, output int k);
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        // Inputs are captured at acceptance; disturb them afterwards.
        rw = ~r; addr = ~a; wdata = ~d;
    endtask

    task automatic run_vec(input vec_t v);
        int k, lat;
        falls_hi = 0; rises_hi = 0; bus_err = 0;
        slv_tx = v.slv_tx;
        issue(v.rw, v.addr, v.wdata, k);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        wait_done(k, v.dbl_at, lat);
        chk("latency", lat, v.exp_lat);
        chk("busy_at_done", busy, 0);
        chk("ack_err", ack_err, v.exp_ack_err);
        chk("rdata", rdata, v.exp_rdata);
        chk("scl_rises", s_r, v.exp_rises);
        if (!v.rw && !v.exp_ack_err) chk("slave_rx", s_rx, v.wdata);
        if (v.rw && !v.exp_ack_err)  chk("master_ack", s_mack, 0);
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("ack_err_hold", ack_err, v.exp_ack_err);
        chk("start_falls", falls_hi, 1);
        chk("stop_rises", rises_hi, 1);
        chk("scl_periods", bus_err, 0);
        chk("bus_idle_scl", scl, 1);
        chk("bus_idle_sda", sda_bus, 1);
    endtask

    initial begin
        int k, lat, seen;

        //          rw addr   wdata  slv_tx ack rdata  lat  rises dbl
        vecs[0] = '{1'b0, 7'h57, 8'hA5, 8'h00, 1'b0, 8'h00, 321, 19, 50};
        vecs[1] = '{1'b1, 7'h57, 8'h00, 8'h3C, 1'b0, 8'h3C, 321, 19, 0};
        vecs[2] = '{1'b0, 7'h12, 8'hA5, 8'h00, 1'b1, 8'h3C, 177, 10, 0};
        vecs[3] = '{1'b1, 7'h12, 8'h00, 8'h99, 1'b1, 8'h3C, 177, 10, 0};
        vecs[4] = '{1'b0, 7'h57, 8'h00, 8'h00, 1'b0, 8'h3C, 321, 19, 0};
        vecs[5] = '{1'b1, 7'h57, 8'h00, 8'hC3, 1'b0, 8'hC3, 321, 19, 0};
        vecs[6] = '{1'b0, 7'h57, 8'hFF, 8'h00, 1'b0, 8'hC3, 321, 19, 0};
        vecs[7] = '{1'b1, 7'h57, 8'h00, 8'h01, 1'b0, 8'h01, 321, 19, 0};

        // Reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_bus, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_state", dbg_state, 4'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during WRITE bit 3 (slot 14 spans edges k+225..k+240).
        issue(1'b0, 7'h57, 8'hA5, k);
        while (cyc < k + 230) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda_bus, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata", rdata, 8'h00);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = seen + 1;
        end
        chk("midrst_no_done", seen, 0);
        mon_en = 1'b1;
        run_vec('{1'b0, 7'h57, 8'h5A, 8'h00, 1'b0, 8'h00, 321, 19, 0});

        // NACK, then start held high from the done cycle onward.
        issue(1'b0, 7'h12, 8'h77, k);
        wait_done(k, 0, lat);
        chk("b2b_nack_lat", lat, 177);
        chk("b2b_nack_err", ack_err, 1);
        rw = 1'b0; addr = 7'h57; wdata = 8'h3C; start = 1'b1;
        @(negedge clk);
        chk("b2b_ignored_busy", busy, 0);
        chk("b2b_ignored_err", ack_err, 1);
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        chk("b2b_err_cleared", ack_err, 0);
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        wait_done(k, 0, lat);
        chk("b2b_latency", lat, 321);
        chk("b2b_ack_err", ack_err, 0);
        chk("b2b_slave_rx", s_rx, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master; it is the initiator paired with the team's I2C slave on the shared `SDA`/`SCL` wired-AND bus. On a `start` pulse it generates START, the 7-bit address, the R/W bit, and one data byte: it writes the byte, or reads one and returns ACK. It then generates STOP and reports completion and acknowledge status to the host logic. It derives `SCL` from the system clock and runs entirely in the `clk` domain.

## Interface
- `CLK_DIV`, 4, system clocks per SCL quarter-period (≥2); one SCL bit period = 4·`CLK_DIV` clocks

- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  one-cycle request; accepted only when `busy`=0
- `rw`  input  1  0 = write byte, 1 = read byte
- `addr`  input  7  target slave address, MSB first on bus
- `wdata`  input  8  byte to write, MSB first
- `rdata`  output  8  byte read from slave, valid when `done`=1 after a read
- `busy`  output  1  high from the cycle after acceptance until `done`
- `done`  output  1  one-cycle pulse at end of transaction
- `ack_err`  output  1  sampled with `done`: 1 = slave NACKed the address or write data
- `SCL`  output  1  bus clock, driven 1/0 (no stretching)
- `SDA`  inout  1  open-drain data: driven 0 or released to 1 (triand bus)

## Operation
- `start` is accepted when `busy`=0. On acceptance `addr`, `rw`, and `wdata` are captured into internal registers. Input changes afterwards have no effect.
- A quarter counter (0..`CLK_DIV`-1) and a phase counter Q0..Q3 subdivide each bit slot:
  - Q0–Q1: `SCL`=0. `SDA` changes only on the first clock of Q0.
  - Q2–Q3: `SCL`=1.
  - Input bits are sampled on the last clock of Q2.
- FSM states and transitions:
  - IDLE: `SCL`=1, `SDA` released. On accepted `start`, go to START.
  - START: `SDA` released in Q0–Q1. `SDA`=0 in Q2–Q3 with `SCL` held 1 for all four quarters (falling SDA while SCL high).
  - ADDR: 7 slots, `addr[6]` first.
  - RW: 1 slot carrying `rw`.
  - ADDR_ACK: `SDA` released and sampled.
    - Sampled 1: set `ack_err`, go to STOP.
    - Sampled 0: go to WRITE if `rw`=0, else READ.
  - WRITE: 8 slots, `wdata[7]` first.
  - WDATA_ACK: `SDA` released and sampled. Sampled 1 sets `ack_err`. Go to STOP.
  - READ: 8 slots with `SDA` released. Each sampled bit is shifted into `rdata`, MSB first.
  - RDATA_ACK: master drives `SDA`=0 (ACK) for the whole slot. Go to STOP.
  - STOP: `SDA`=0 in Q0–Q2. `SCL`=0 in Q0–Q1 and 1 in Q2–Q3. `SDA` is released in Q3 (rising SDA while SCL high). Then pulse `done` and return to IDLE.
- `ack_err` is cleared on acceptance of a new `start`. It holds its value until the next `start` is accepted.
- `rdata` updates only during READ and otherwise holds its value.
- Clock stretching, arbitration, repeated START, and multi-byte transfers are not supported.

## Timing
- Reset values: `SCL`=1, `SDA` released (1), `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, FSM=IDLE, all counters 0.
- `start` sampled high at edge k → START slot begins at edge k+1 and `busy`=1 from k+1.
- Slot count per transaction:
  - Write or read with address ACK: 20 slots (START + 7 + 1 + 1 + 8 + 1 + STOP).
  - Address NACK: 11 slots (START + 7 + 1 + 1 + STOP).
- `done`=1 and `busy`=0 at cycle k+1+N·4·`CLK_DIV`, where N is the slot count.
  - With `CLK_DIV`=4 and a full transaction: `done` at k+321.
- `start` while `busy`=1: ignored, with no effect on the current transfer.
- `start` in the same cycle as `done`: ignored. It is accepted from the cycle after `done` onward.
- `rst` mid-transaction: on the next edge all outputs return to their reset values. `SCL`=1 and `SDA` released, which the slave sees as STOP or bus idle. No `done` pulse is produced.

## Test plan
- Write to the paired slave (address 7'h57), `wdata`=8'hA5, `CLK_DIV`=4 → slave `DATA_out`=8'hA5. `ack_err`=0. `done` exactly 321 cycles after the `start` edge.
- Read from 7'h57 → `rdata` equals the slave's transmitted byte, and the slave's `DATA_read` matches it. Master drives ACK=0 in slot 19. `ack_err`=0.
- Write to unmatched address 7'h12 → `ack_err`=1. `done` at k+177. No data slots appear on `SDA`. STOP is observed and `SDA`/`SCL` end at 1/1.
- Bus-level check on every transaction:
  - `SDA` never changes while `SCL`=1, except for the single START fall and the single STOP rise.
  - `SCL` high and low periods are each 2·`CLK_DIV`.
- Second `start` pulse at k+50 during a write → ignored, with a single `done` at k+321. Back-to-back `start` at the cycle after `done` → accepted. `ack_err` is cleared on acceptance.
- `rst` asserted during WRITE bit 3 → next cycle `SCL`=1, `SDA`=1, `busy`=0, `rdata`=0, with no `done` pulse. A new write afterwards completes normally.
